// File: rtl/datapath_reg_alu.sv
// datapath_reg_alu: 64-bit datapath slice of a single-cycle ARM-style core.
// A 32x64 register file (R31 hardwired to zero, two combinational read
// ports, one write port) feeds a 64-bit ALU whose result is both the `data`
// output and the write-back value for register DA.
// Optional build macro: DATAPATH_STATUS_REG_EN -- when defined, `status` is a
// registered copy of the ALU flags; otherwise it is combinational.
module datapath_reg_alu (
    input  logic [4:0]  DA,
    input  logic [4:0]  SA,
    input  logic [4:0]  SB,
    input  logic        W,
    input  logic        reset,
    input  logic        clock,
    input  logic [63:0] K,
    input  logic        BS,
    input  logic [4:0]  FS,
    output logic [3:0]  status,
    output logic [63:0] data
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_SLL = 3'b100,
        OP_SRL = 3'b101
    } alu_op_e;

    localparam logic [4:0] XZR = 5'd31;

    // R0..R30 only; R31 is never stored and always reads as zero.
    logic [63:0] r_regs [0:30];

    logic [63:0] w_a;
    logic [63:0] w_b_reg;
    logic [63:0] w_b;
    logic [63:0] w_a_c;
    logic [63:0] w_b_c;
    logic [64:0] w_sum;
    logic [63:0] w_result;
    logic        w_carry;
    logic        w_ovf;
    logic [3:0]  w_flags;
    alu_op_e     w_op;

    // Combinational read ports with XZR decode, then B operand select.
    always_comb begin
        w_a     = (SA == XZR) ? 64'd0 : r_regs[SA];
        w_b_reg = (SB == XZR) ? 64'd0 : r_regs[SB];
        w_b     = BS ? K : w_b_reg;
    end

    // Operand conditioning: FS[1] inverts A, FS[0] inverts B and adds carry-in.
    always_comb begin
        w_a_c = FS[1] ? ~w_a : w_a;
        w_b_c = FS[0] ? ~w_b : w_b;
        w_sum = {1'b0, w_a_c} + {1'b0, w_b_c} + {64'd0, FS[0]};
        w_op  = alu_op_e'(FS[4:2]);
    end

    // Function select; carry and overflow are only meaningful for ADD.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held (no latch).
        w_result = 64'd0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (w_op)
            OP_AND: w_result = w_a_c & w_b_c;
            OP_OR:  w_result = w_a_c | w_b_c;
            OP_ADD: begin
                w_result = w_sum[63:0];
                w_carry  = w_sum[64];
                w_ovf    = (w_a_c[63] == w_b_c[63]) && (w_sum[63] != w_a_c[63]);
            end
            OP_XOR: w_result = w_a_c ^ w_b_c;
            // Shift amount is the raw B[5:0]; B inversion does not apply to it.
            OP_SLL: w_result = w_a_c << w_b[5:0];
            OP_SRL: w_result = w_a_c >> w_b[5:0];
            default: w_result = 64'd0;
        endcase
    end

    assign data    = w_result;
    assign w_flags = {w_ovf, w_carry, w_result[63], (w_result == 64'd0)};

    // Register file write: async clear of R0..R30, write-back of the ALU result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the register file is a reset-able memory here because the
            // core relies on all registers reading zero right after reset; this
            // forces flops rather than a RAM macro.
            for (int i = 0; i < 31; i++) begin
                r_regs[i] <= 64'd0;
            end
        end else if (W && (DA != XZR)) begin
            // NOTE: non-blocking so reads in this cycle see the old value and
            // the write becomes visible only after the edge.
            r_regs[DA] <= data;
        end
    end

`ifdef DATAPATH_STATUS_REG_EN
    logic [3:0] r_status;

    // Registered flags, captured every clock and cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_status <= 4'b0000;
        end else begin
            r_status <= w_flags;
        end
    end

    assign status = r_status;
`else
    assign status = w_flags;
`endif

endmodule

// File: tb/tb_datapath_reg_alu.sv
// Self-checking bench for datapath_reg_alu: a behavioural register-file/ALU
// model checked against the DUT every falling edge, plus literal expectations
// for the directed vectors.
module tb_datapath_reg_alu;

    logic [4:0]  DA, SA, SB, FS;
    logic        W, reset, clock, BS;
    logic [63:0] K;
    logic [3:0]  status;
    logic [63:0] data;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state: index 31 is never written, so it stays zero.
    logic [63:0] m_regs [0:31];
    logic [3:0]  m_status_q;

    datapath_reg_alu dut (
        .DA    (DA),
        .SA    (SA),
        .SB    (SB),
        .W     (W),
        .reset (reset),
        .clock (clock),
        .K     (K),
        .BS    (BS),
        .FS    (FS),
        .status(status),
        .data  (data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns {V,C,N,Z, result} computed from the current inputs and the model file.
    function automatic logic [67:0] model_eval();
        logic [63:0] a, b, ac, bc, r;
        logic [64:0] wide;
        logic        c, v, a_pos, b_pos, r_pos;
        int          sh;
        a  = (SA == 5'd31) ? 64'd0 : m_regs[SA];
        b  = BS ? K : ((SB == 5'd31) ? 64'd0 : m_regs[SB]);
        ac = FS[1] ? ~a : a;
        bc = FS[0] ? ~b : b;
        sh = int'(b[5:0]);
        c  = 1'b0;
        v  = 1'b0;
        r  = 64'd0;
        case (FS[4:2])
            3'd0: r = ac & bc;
            3'd1: r = ac | bc;
            3'd2: begin
                wide  = 65'(ac) + 65'(bc) + 65'(FS[0]);
                r     = wide[63:0];
                c     = (wide >= 65'h1_0000_0000_0000_0000);
                a_pos = ($signed(ac) >= 0);
                b_pos = ($signed(bc) >= 0);
                r_pos = ($signed(r) >= 0);
                v     = (a_pos == b_pos) && (r_pos != a_pos);
            end
            3'd3: r = ac ^ bc;
            3'd4: r = ac << sh;
            3'd5: r = ac >> sh;
            default: r = 64'd0;
        endcase
        return {v, c, r[63], (r == 64'd0), r};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_status_q = 4'b0000;
    end

    // Model update: clear on reset, otherwise write back to DA (never R31).
    always @(posedge clock or negedge reset) begin
        logic [67:0] ev;
        ev = model_eval();
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            m_status_q = 4'b0000;
        end else begin
            m_status_q = ev[67:64];
            if (W && DA != 5'd31) m_regs[DA] = ev[63:0];
        end
    end

    // Continuous compare against the model on every falling edge.
    always @(negedge clock) begin
        logic [67:0] ev;
        ev = model_eval();
        check("model_data", data, ev[63:0]);
`ifdef DATAPATH_STATUS_REG_EN
        check("model_status", 64'(status), 64'(m_status_q));
`else
        check("model_status", 64'(status), 64'(ev[67:64]));
`endif
    end

    task automatic drive(input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                         input logic w, input logic [63:0] k, input logic bs,
                         input logic [4:0] fs);
        DA = da; SA = sa; SB = sb; W = w; K = k; BS = bs; FS = fs;
    endtask

    // Apply a vector just after a rising edge, then sample after the falling edge.
    task automatic step(input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                        input logic w, input logic [63:0] k, input logic bs,
                        input logic [4:0] fs);
        @(posedge clock);
        #1;
        drive(da, sa, sb, w, k, bs, fs);
        @(negedge clock);
        #1;
    endtask

    task automatic check_status(input string name, input logic [3:0] exp);
`ifndef DATAPATH_STATUS_REG_EN
        check(name, 64'(status), 64'(exp));
`else
        n_checks = n_checks + 0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 5'b00000);
        #2 reset = 1'b0;
        @(negedge clock);
        #1;
        check("reset_data", data, 64'd0);
        check_status("reset_status_z", 4'b0001);
        @(posedge clock);
        #1 reset = 1'b1;

        // R5 = 0 | 24
        step(5'd5, 5'd31, 5'd0, 1'b1, 64'd24, 1'b1, 5'b00100);
        check("or_imm_24", data, 64'd24);
        check_status("or_imm_24_st", 4'b0000);
        // R7 = 39
        step(5'd7, 5'd31, 5'd0, 1'b1, 64'd39, 1'b1, 5'b00100);
        check("or_imm_39", data, 64'd39);
        // R1 = R5 + R7
        step(5'd1, 5'd5, 5'd7, 1'b1, 64'd0, 1'b0, 5'b01000);
        check("add_63", data, 64'd63);
        check_status("add_63_st", 4'b0000);
        // R30 = R1 ^ R5
        step(5'd30, 5'd1, 5'd5, 1'b1, 64'd0, 1'b0, 5'b01100);
        check("xor_39", data, 64'd39);
        // R17 = R30 << 2
        step(5'd17, 5'd30, 5'd0, 1'b1, 64'd2, 1'b1, 5'b10000);
        check("sll_156", data, 64'd156);
        // Read back R17 via OR with XZR
        step(5'd0, 5'd17, 5'd31, 1'b0, 64'd0, 1'b0, 5'b00100);
        check("readback_r17", data, 64'd156);
        // Shift boundaries: amount 0, amount 64 (B[5:0]=0), right shift by 3
        step(5'd0, 5'd17, 5'd0, 1'b0, 64'd0, 1'b1, 5'b10000);
        check("sll_by_0", data, 64'd156);
        step(5'd0, 5'd17, 5'd0, 1'b0, 64'd64, 1'b1, 5'b10000);
        check("sll_by_64_mod", data, 64'd156);
        step(5'd0, 5'd17, 5'd0, 1'b0, 64'd3, 1'b1, 5'b10100);
        check("srl_by_3", data, 64'd19);
        step(5'd0, 5'd17, 5'd0, 1'b0, 64'd3, 1'b1, 5'b11000);
        check("op_110_zero", data, 64'd0);
        // 24 - 24
        step(5'd0, 5'd5, 5'd5, 1'b0, 64'd0, 1'b0, 5'b01001);
        check("sub_zero", data, 64'd0);
        check_status("sub_zero_st", 4'b0101);
        // 0 - 1
        step(5'd0, 5'd31, 5'd0, 1'b0, 64'd1, 1'b1, 5'b01001);
        check("sub_neg1", data, 64'hFFFF_FFFF_FFFF_FFFF);
        check_status("sub_neg1_st", 4'b0010);
        // Write to R31 is discarded
        step(5'd31, 5'd31, 5'd0, 1'b1, 64'd5, 1'b1, 5'b00100);
        check("xzr_write_data", data, 64'd5);
        step(5'd0, 5'd31, 5'd31, 1'b0, 64'd0, 1'b0, 5'b00100);
        check("xzr_reads_zero", data, 64'd0);
        // Signed overflow: 0x7FFF...F + 1
        step(5'd2, 5'd31, 5'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 5'b00100);
        step(5'd0, 5'd2, 5'd0, 1'b0, 64'd1, 1'b1, 5'b01000);
        check("ovf_data", data, 64'h8000_0000_0000_0000);
        check_status("ovf_st", 4'b1010);

        // Mid-cycle reset with a pending write to R9
        step(5'd9, 5'd5, 5'd31, 1'b1, 64'd0, 1'b0, 5'b00100);
        check("pre_reset_r5", data, 64'd24);
        #1 reset = 1'b0;
        #1;
        check("in_reset_r5", data, 64'd0);
        check_status("in_reset_st", 4'b0001);
        @(posedge clock);
        #1;
        W = 1'b0;
        reset = 1'b1;
        step(5'd0, 5'd5, 5'd31, 1'b0, 64'd0, 1'b0, 5'b00100);
        check("post_reset_r5", data, 64'd0);
        step(5'd0, 5'd9, 5'd31, 1'b0, 64'd0, 1'b0, 5'b00100);
        check("post_reset_r9", data, 64'd0);
        step(5'd0, 5'd17, 5'd30, 1'b0, 64'd0, 1'b0, 5'b00100);
        check("post_reset_r17_r30", data, 64'd0);

        @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
